// File: rtl/kmeans_adder_sched_if.sv
// Requester and adder-side signals of the shared-adder scheduler.
// slave is the scheduler's view; master is the view of whatever drives it (requesters + adder).
interface kmeans_adder_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][DW-1:0] req_a;
  logic [NREQ-1:0][DW-1:0] req_b;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         rsp_valid;
  logic [DW-1:0]           rsp_z;
  logic                    clear;
  logic                    busy;
  logic [31:0]             op_count;
  logic [DW-1:0]           add_a;
  logic [DW-1:0]           add_b;
  logic                    add_a_stb;
  logic                    add_b_stb;
  logic                    add_a_ack;
  logic                    add_b_ack;
  logic [DW-1:0]           add_z;
  logic                    add_z_stb;
  logic                    add_z_ack;

  modport slave (
    input  req_valid, req_a, req_b, clear, add_a_ack, add_b_ack, add_z, add_z_stb,
    output req_ready, rsp_valid, rsp_z, busy, op_count, add_a, add_b,
           add_a_stb, add_b_stb, add_z_ack
  );

  modport master (
    output req_valid, req_a, req_b, clear, add_a_ack, add_b_ack, add_z, add_z_stb,
    input  req_ready, rsp_valid, rsp_z, busy, op_count, add_a, add_b,
           add_a_stb, add_b_stb, add_z_ack
  );
endinterface

// File: rtl/kmeans_adder_sched.sv
// Round-robin scheduler sharing one stb/ack float adder among NREQ requesters.
// One operation in flight; each sum is routed back to the requester that issued it.
module kmeans_adder_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 32
) (
  input logic                  clk,
  input logic                  rstnn,
  kmeans_adder_sched_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, id, gnt_id, ptr_base;
  logic [SW-1:0] sum;
  logic          gnt, found, a_taken, b_taken;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt) state_nxt = ISSUE;
      ISSUE:   if (a_taken && b_taken) state_nxt = WAIT;
      WAIT:    if (bus.add_z_stb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration: a same-cycle clear restarts the search from 0.
  // Scanning high-to-low leaves the first valid index at/after ptr_base.
  always_comb begin
    sum      = '0;
    found    = 1'b0;
    gnt_id   = '0;
    ptr_base = bus.clear ? '0 : ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_base} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      if (bus.req_valid[sum[IW-1:0]]) begin
        found  = 1'b1;
        gnt_id = sum[IW-1:0];
      end
    end
    gnt      = found && (state == IDLE);
    a_taken  = !bus.add_a_stb || bus.add_a_ack;
    b_taken  = !bus.add_b_stb || bus.add_b_ack;
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      ptr           <= '0;
      id            <= '0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      bus.add_a_stb <= 1'b0;
      bus.add_b_stb <= 1'b0;
      bus.add_z_ack <= 1'b0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_z     <= '0;
      bus.op_count  <= '0;
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (bus.clear) begin
            ptr          <= '0;
            bus.op_count <= '0;
          end
          if (gnt) begin
            bus.add_a     <= bus.req_a[gnt_id];
            bus.add_b     <= bus.req_b[gnt_id];
            id            <= gnt_id;
            bus.req_ready <= ONE << gnt_id;
            bus.add_a_stb <= 1'b1;
            bus.add_b_stb <= 1'b1;
            ptr           <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
          end
        end
        ISSUE: begin
          if (bus.add_a_stb && bus.add_a_ack) bus.add_a_stb <= 1'b0;
          if (bus.add_b_stb && bus.add_b_ack) bus.add_b_stb <= 1'b0;
          if (a_taken && b_taken) bus.add_z_ack <= 1'b1;
        end
        WAIT: begin
          if (bus.add_z_stb) begin
            bus.rsp_z     <= bus.add_z;
            bus.rsp_valid <= ONE << id;
            bus.add_z_ack <= 1'b0;
            bus.op_count  <= bus.op_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kmeans_adder_sched.sv
// Bench for kmeans_adder_sched: stb/ack adder model, transaction-level scoreboard,
// table of single-request vectors and directed multi-cycle sequences.
module tb_kmeans_adder_sched;
  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic clk   = 1'b0;
  logic rstnn = 1'b1;
  always #5 clk = ~clk;

  kmeans_adder_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();
  kmeans_adder_sched #(.NREQ(NREQ), .DW(DW)) dut (.clk(clk), .rstnn(rstnn), .bus(bus));

  typedef struct {int id; logic [31:0] z;} exp_t;
  typedef struct {
    int id; logic [31:0] a; logic [31:0] b;
    int ad; int bd; int zd; logic [31:0] z;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  exp_t q[$];
  int glog[$];

  // reference state
  int          m_ptr;
  bit          m_idle;
  logic [31:0] m_cnt, m_last_z;
  int          last_g;
  // adder model state
  int a_dly, b_dly, z_dly, a_cnt, b_cnt, z_cnt;
  bit a_done, b_done, rand_dly;
  // requester behaviour
  bit cont_mode, auto_mode;
  // observation logs
  int cyc, rdy_cyc, rsp_cyc, rdy_cnt, rsp_cnt;
  logic [NREQ-1:0] rdy_or, rsp_or;

  // The scheduler never looks at operand values, so the adder is a cheap stand-in
  // with the property that 1.0 + 2.0 yields the bit pattern of 3.0.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return a + b - 32'h3F40_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic new_ops(input int i);
    bus.req_a[i] = $urandom;
    bus.req_b[i] = $urandom;
  endtask

  task automatic clear_logs();
    rdy_or = '0; rsp_or = '0; rdy_cnt = 0; rsp_cnt = 0; rdy_cyc = 0; rsp_cyc = 0;
  endtask

  task automatic monitor();
    int   g;
    exp_t e;
    if (!rstnn) return;
    cyc++;
    g = -1;
    if (m_idle) begin
      if (bus.clear) begin m_ptr = 0; m_cnt = 0; end
      for (int k = NREQ - 1; k >= 0; k--)
        if (bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    end
    last_g = g;
    chk("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    if (g >= 0) begin
      chk("issue_stbs", {30'd0, bus.add_a_stb, bus.add_b_stb}, 32'd3);
      m_ptr  = (g + 1) % NREQ;
      m_idle = 1'b0;
      glog.push_back(g);
      e.id = g;
      e.z  = fadd(bus.req_a[g], bus.req_b[g]);
      q.push_back(e);
    end
    if (bus.req_ready != 0) begin rdy_or |= bus.req_ready; rdy_cnt++; rdy_cyc = cyc; end
    if (bus.rsp_valid != 0) begin rsp_or |= bus.rsp_valid; rsp_cnt++; rsp_cyc = cyc; end
    if (bus.add_z_stb) begin
      // a result handshake happened on the edge just passed
      if (q.size() == 0) fail_now("rsp_without_request");
      else begin
        e = q.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << e.id);
        chk("rsp_z", bus.rsp_z, e.z);
        m_last_z = e.z;
      end
      m_cnt++;
      m_idle = 1'b1;
    end else chk("rsp_quiet", 32'(bus.rsp_valid), 32'd0);
    chk("rsp_z_hold", bus.rsp_z, m_last_z);
    chk("op_count", bus.op_count, m_cnt);
    chk("busy", 32'(bus.busy), 32'(!m_idle));
  endtask

  task automatic adder_step();
    if (!rstnn) return;
    if (bus.add_z_stb) begin
      bus.add_z_stb = 1'b0;
      a_done = 1'b0; b_done = 1'b0; z_cnt = 0;
      if (rand_dly) begin
        a_dly = $urandom_range(0, 4); b_dly = $urandom_range(0, 4); z_dly = $urandom_range(0, 4);
      end
    end
    if (bus.add_a_ack) begin
      chk("a_stb_drop", 32'(bus.add_a_stb), 32'd0);
      bus.add_a_ack = 1'b0; a_done = 1'b1;
    end else if (bus.add_a_stb) begin
      if (a_cnt >= a_dly) begin bus.add_a_ack = 1'b1; a_cnt = 0; end
      else a_cnt++;
    end
    if (bus.add_b_ack) begin
      chk("b_stb_drop", 32'(bus.add_b_stb), 32'd0);
      bus.add_b_ack = 1'b0; b_done = 1'b1;
    end else if (bus.add_b_stb) begin
      if (b_cnt >= b_dly) begin bus.add_b_ack = 1'b1; b_cnt = 0; end
      else b_cnt++;
    end
    chk("z_ack_window", 32'(bus.add_z_ack), 32'(a_done && b_done));
    if (a_done && b_done) begin
      if (z_cnt >= z_dly) begin
        bus.add_z_stb = 1'b1;
        bus.add_z     = fadd(bus.add_a, bus.add_b);
      end else z_cnt++;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (last_g == i) begin
        if (cont_mode || (auto_mode && $urandom_range(0, 1) == 1)) new_ops(i);
        else bus.req_valid[i] = 1'b0;
      end else if (auto_mode && !bus.req_valid[i] && $urandom_range(0, 5) == 0) begin
        bus.req_valid[i] = 1'b1;
        new_ops(i);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    adder_step();
    drive_reqs();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    do begin tick(); n++; end
    while (!(m_idle && q.size() == 0 && bus.req_valid == 0) && n < budget);
    if (!(m_idle && q.size() == 0 && bus.req_valid == 0)) fail_now("run_idle_timeout");
  endtask

  task automatic do_reset();
    rstnn = 1'b0;
    bus.req_valid = '0; bus.clear = 1'b0;
    bus.add_a_ack = 1'b0; bus.add_b_ack = 1'b0; bus.add_z_stb = 1'b0; bus.add_z = '0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_z", bus.rsp_z, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_op_count", bus.op_count, 32'd0);
    chk("rst_add_ab", bus.add_a | bus.add_b, 32'd0);
    chk("rst_stbs", {29'd0, bus.add_a_stb, bus.add_b_stb, bus.add_z_ack}, 32'd0);
    m_ptr = 0; m_idle = 1'b1; m_cnt = '0; m_last_z = '0; last_g = -1;
    q.delete(); glog.delete(); clear_logs();
    a_cnt = 0; b_cnt = 0; z_cnt = 0; a_done = 1'b0; b_done = 1'b0;
    repeat (2) @(negedge clk);
    rstnn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   gexp[6];
    int   n;
    vt[0] = '{id: 2, a: 32'h3F80_0000, b: 32'h4000_0000, ad: 0, bd: 0, zd: 0, z: 32'h4040_0000};
    vt[1] = '{id: 0, a: 32'h0000_0000, b: 32'h0000_0000, ad: 1, bd: 1, zd: 2, z: 32'hC0C0_0000};
    vt[2] = '{id: 3, a: 32'h3F40_0000, b: 32'h1234_5678, ad: 0, bd: 3, zd: 5, z: 32'h1234_5678};
    vt[3] = '{id: 1, a: 32'hFFFF_FFFF, b: 32'h3F40_0001, ad: 2, bd: 0, zd: 1, z: 32'h0000_0000};
    vt[4] = '{id: 2, a: 32'h4049_0FDB, b: 32'h3F40_0000, ad: 4, bd: 4, zd: 0, z: 32'h4049_0FDB};
    gexp = '{0, 1, 2, 3, 0, 1};
    cont_mode = 1'b0; auto_mode = 1'b0; rand_dly = 1'b0; cyc = 0;
    bus.req_a = '0; bus.req_b = '0;
    a_dly = 0; b_dly = 0; z_dly = 0;
    #2;
    do_reset();

    // single-request vectors
    for (int r = 0; r < 5; r++) begin
      clear_logs();
      a_dly = vt[r].ad; b_dly = vt[r].bd; z_dly = vt[r].zd;
      bus.req_a[vt[r].id] = vt[r].a;
      bus.req_b[vt[r].id] = vt[r].b;
      bus.req_valid[vt[r].id] = 1'b1;
      run_idle(100);
      chk("tv_ready", 32'(rdy_or), 32'd1 << vt[r].id);
      chk("tv_ready_n", rdy_cnt, 1);
      chk("tv_rsp", 32'(rsp_or), 32'd1 << vt[r].id);
      chk("tv_rsp_n", rsp_cnt, 1);
      chk("tv_z", bus.rsp_z, vt[r].z);
      chk("tv_count", bus.op_count, r + 1);
      chk("tv_busy", 32'(bus.busy), 32'd0);
      chk("tv_latency", rsp_cyc - rdy_cyc,
          2 + ((vt[r].ad > vt[r].bd) ? vt[r].ad : vt[r].bd) + vt[r].zd);
    end

    // all four requesting continuously from reset
    do_reset();
    a_dly = 1; b_dly = 0; z_dly = 2;
    cont_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    bus.req_valid = '1;
    n = 0;
    while (glog.size() < 6 && n < 200) begin tick(); n++; end
    cont_mode = 1'b0;
    run_idle(200);
    if (glog.size() < 6) fail_now("rr_too_few_grants");
    else for (int i = 0; i < 6; i++) chk("rr_order", glog[i], gexp[i]);

    // requester 1 withdraws while 0 is in flight; 3 is next, then ptr wraps to 0
    do_reset();
    a_dly = 0; b_dly = 0; z_dly = 4;
    new_ops(0); bus.req_valid[0] = 1'b1;
    tick();
    new_ops(1); new_ops(3); bus.req_valid[1] = 1'b1; bus.req_valid[3] = 1'b1;
    tick();
    bus.req_valid[1] = 1'b0;
    run_idle(100);
    new_ops(0); new_ops(1); bus.req_valid[0] = 1'b1; bus.req_valid[1] = 1'b1;
    run_idle(100);
    if (glog.size() != 4) fail_now("skip_grant_count");
    else begin
      chk("skip_g0", glog[0], 0); chk("skip_g1", glog[1], 3);
      chk("skip_g2", glog[2], 0); chk("skip_g3", glog[3], 1);
    end

    // clear while busy is ignored; clear in IDLE wins over ptr and zeroes the count
    do_reset();
    a_dly = 0; b_dly = 0; z_dly = 3;
    new_ops(0); bus.req_valid[0] = 1'b1;
    run_idle(100);
    new_ops(1); bus.req_valid[1] = 1'b1;
    tick(); tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    run_idle(100);
    chk("clr_busy_count", bus.op_count, 32'd2);
    new_ops(1); new_ops(3);
    bus.req_valid = 4'b1010;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_grant", glog[glog.size() - 1], 1);
    chk("clr_count", bus.op_count, 32'd0);
    run_idle(100);
    chk("clr_after", bus.op_count, 32'd2);

    // reset while waiting on the adder result
    do_reset();
    a_dly = 0; b_dly = 0; z_dly = 10;
    new_ops(2); bus.req_valid[2] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.add_z_ack && n < 20);
    if (!bus.add_z_ack) fail_now("wait_state_not_reached");
    do_reset();
    z_dly = 1;
    new_ops(0); bus.req_valid[0] = 1'b1;
    run_idle(100);
    chk("post_rst_count", bus.op_count, 32'd1);
    chk("post_rst_rsp", 32'(rsp_or), 32'd1);

    // randomized traffic, random adder timing and occasional clear pulses
    rand_dly = 1'b1; auto_mode = 1'b1;
    for (int c = 0; c < 500; c++) begin
      bus.clear = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.clear = 1'b0;
    auto_mode = 1'b0;
    run_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/kmeans_adder_sched.md
# kmeans_adder_sched

Shares one handshaked single-precision float adder (`adder_jn` stb/ack protocol) between `NREQ` accumulation requesters in the k-means datapath. It replaces per-point adder instances in the cluster-sum stage. Requesters post operand pairs. The scheduler grants them round-robin, drives the adder's input strobes and output acknowledge, and returns each sum to the requester that issued it. Exactly one operation is in flight at a time.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `DW`, 32: operand/result width (IEEE-754 single).

Ports:
- `clk` in 1: clock, rising edge.
- `rstnn` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: bit i high means requester i has an operand pair pending.
- `req_a` in NREQ*DW: operand A, slice i = bits [i*DW +: DW].
- `req_b` in NREQ*DW: operand B, same packing.
- `req_ready` out NREQ: one-hot, one-cycle pulse; the operands of that requester have been captured.
- `rsp_valid` out NREQ: one-hot, one-cycle pulse; `rsp_z` belongs to that requester.
- `rsp_z` out DW: last result, held until the next completion.
- `clear` in 1: synchronous; zeroes the RR pointer and `op_count`; honored only in IDLE.
- `busy` out 1: high when state is not IDLE.
- `op_count` out 32: completed operations, wraps at 2^32.
- `add_a`, `add_b` out DW: adder operands.
- `add_a_stb`, `add_b_stb` out 1: adder input strobes.
- `add_a_ack`, `add_b_ack` in 1: adder input acknowledges.
- `add_z` in DW: adder result.
- `add_z_stb` in 1: adder result strobe.
- `add_z_ack` out 1: result acknowledge.

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE**
  - If any `req_valid` bit is set, grant the lowest index >= `ptr` that is valid, wrapping modulo NREQ.
  - On the grant edge:
    - capture `req_a`/`req_b` slices into `add_a`/`add_b`
    - store `id`
    - set `req_ready[id]`=1 for one cycle
    - set `add_a_stb`=`add_b_stb`=1
    - `ptr`<=`id`+1 (mod NREQ)
    - go to ISSUE
  - If `clear` and `req_valid` are both high in the same IDLE cycle, `clear` applies first (`ptr`=0) and the grant uses `ptr`=0.
- **ISSUE**
  - On an edge where `add_a_stb`&&`add_a_ack`, drive `add_a_stb`<=0. The B side is handled independently the same way.
  - When both strobes have been taken (both acks in the same edge is allowed): `add_z_ack`<=1, go to WAIT.
- **WAIT**
  - On an edge with `add_z_stb`:
    - `rsp_z`<=`add_z`
    - `rsp_valid[id]`<=1 for one cycle
    - `add_z_ack`<=0
    - `op_count`+=1
    - go to IDLE
- Operands are held stable in `add_a`/`add_b` from grant until WAIT exits.
- Requesters must hold `req_valid` and operands until they see `req_ready`, then may change them.
- A requester dropping `req_valid` before being granted is legal; it is simply skipped.
- `clear` outside IDLE is ignored.
- No arithmetic is done here. `op_count` and `ptr` are plain wrap-around counters.

## Timing
- Reset values: all outputs 0, `ptr`=0, state IDLE.
- Reset mid-operation aborts the operation with no response. The adder shares `rstnn`, so no stale `add_z_stb` is expected.
- `req_ready[id]` is high in the first ISSUE cycle. ISSUE blocks a second grant in that cycle, so there is no double grant.
- Latency: from grant edge to `rsp_valid` = adder latency + 2 cycles (minimum).
- `rsp_valid` is high during the first cycle back in IDLE. A new grant may occur on that same edge; back-to-back throughput is one grant per adder op + 2 cycles.
- Strobes never re-assert after their ack within one operation.
- `add_z_ack` is high only in WAIT.

## Test plan
- Single request: req 2, a=0x3F800000 (1.0), b=0x40000000 (2.0) -> one `req_ready`=0b0100 pulse, later `rsp_valid`=0b0100 with `rsp_z`=0x40400000, `op_count`=1, `busy` low afterwards.
- All four requesting continuously from reset -> grant order 0,1,2,3,0,1 and each `rsp_valid` id matches the preceding grant id.
- Adder model acks A 3 cycles before B, and holds `add_z_stb` with 5-cycle delay -> each strobe drops exactly one cycle after its ack; `add_z_ack` only in WAIT; no extra `rsp_valid`.
- Requester 1 drops `req_valid` while 0 is in flight, and 3 is valid -> the next grant is 3 (1 skipped); `ptr` becomes 0.
- `clear` pulsed while busy -> `op_count` unchanged. `clear` pulsed in IDLE together with req_valid=0b1010 and `ptr`=2 -> `op_count`=0 and requester 1 is granted.
- `rstnn` asserted in WAIT -> all outputs 0 immediately; after release a new request completes normally with `op_count`=1.
